// File: rtl/fpu_bus_if.sv
// ---------------------------------------------------------------------------
// fpu_bus_if
//
// Purpose: 8-bit CPU bus front end for a purely combinational floating-point
// unit. The CPU loads two 32-bit operands byte by byte, issues a command, and
// the block holds the operands and operation steady for SETTLE_CYCLES clocks
// while the fpu settles. It then captures the fpu result into a RESULT
// register that the CPU reads back byte by byte.
//
// Register map (byte addresses):
//   0-3   A operand, little-endian (0 = A[7:0])
//   4-7   B operand, little-endian
//   8     CMD (write only): bit 7 = start, bits 1:0 = operation
//   9     STATUS (read only): {6'b0, done, busy}
//   10,11 reserved: read as 0x00, writes ignored
//   12-15 RESULT, little-endian, read only; reading 15 acknowledges a result
//
// Ports:
//   clk             rising-edge clock
//   arst            asynchronous active-high reset
//   cs, wr, rd      bus chip select and strobes (a write wins over a read)
//   addr, data_in   register select and write data
//   data_out        registered read data, held between reads
//   busy            operation in progress (SETTLE or CAPTURE)
//   done            result held and not yet acknowledged
//   a_operand       operand A to the fpu
//   b_operand       operand B to the fpu
//   operation       operation to the fpu
//   ieee_packet_out combinational fpu result
// ---------------------------------------------------------------------------
package pa_fpu;
  typedef enum logic [1:0] {
    op_add = 2'd0,
    op_sub = 2'd1,
    op_mul = 2'd2,
    op_div = 2'd3
  } e_fpu_op;
endpackage

module fpu_bus_if #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             cs,
  input  logic             wr,
  input  logic             rd,
  input  logic [3:0]       addr,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_out,
  output logic             busy,
  output logic             done,
  output logic [31:0]      a_operand,
  output logic [31:0]      b_operand,
  output pa_fpu::e_fpu_op  operation,
  input  logic [31:0]      ieee_packet_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } e_state;

  // Counter value on the final SETTLE cycle.
  localparam logic [3:0] LP_LAST = 4'(SETTLE_CYCLES - 1);

  localparam logic [3:0] LP_ADDR_CMD    = 4'd8;
  localparam logic [3:0] LP_ADDR_STATUS = 4'd9;
  localparam logic [3:0] LP_ADDR_ACK    = 4'd15;

  e_state          r_state;
  e_state          w_next;
  logic [3:0]      r_cnt;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [31:0]     r_result;
  pa_fpu::e_fpu_op r_op;
  logic [7:0]      r_data_out;

  logic            w_wr;
  logic            w_rd;
  logic            w_open;
  logic            w_start;
  logic            w_busy;
  logic            w_done;
  logic [7:0]      w_rdata;
  logic            w_unused_cmd_bits;

  // A write takes priority: a simultaneous read is dropped entirely.
  assign w_wr    = cs & wr;
  assign w_rd    = cs & rd & ~wr;
  // Operand and command writes are only accepted while no operation runs.
  assign w_open  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start = w_wr && w_open && (addr == LP_ADDR_CMD) && data_in[7];
  assign w_busy  = (r_state == ST_SETTLE) || (r_state == ST_CAPTURE);
  assign w_done  = (r_state == ST_DONE);

  // CMD bits 6:2 carry no meaning.
  assign w_unused_cmd_bits = ^data_in[6:2];

  // State register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_cnt == LP_LAST) w_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_next = ST_DONE;
      end
      ST_DONE: begin
        if (w_start) begin
          w_next = ST_SETTLE;
        end else if (w_rd && (addr == LP_ADDR_ACK)) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Settle counter: zero on entry to SETTLE, counts every SETTLE cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt <= 4'd0;
    end else if (w_start) begin
      r_cnt <= 4'd0;
    end else if (r_state == ST_SETTLE) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Operand and operation registers, frozen while busy.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_a  <= 32'd0;
      r_b  <= 32'd0;
      r_op <= pa_fpu::op_add;
    end else begin
      if (w_wr && w_open && !addr[3]) begin
        if (!addr[2]) begin
          r_a[{addr[1:0], 3'b000} +: 8] <= data_in;
        end else begin
          r_b[{addr[1:0], 3'b000} +: 8] <= data_in;
        end
      end
      if (w_start) begin
        r_op <= pa_fpu::e_fpu_op'(data_in[1:0]);
      end
    end
  end

  // Result capture, one cycle after the settle window closes.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_result <= 32'd0;
    end else if (r_state == ST_CAPTURE) begin
      r_result <= ieee_packet_out;
    end
  end

  // Read data mux; unmapped and write-only addresses read as zero.
  always_comb begin
    w_rdata = 8'h00;
    if (!addr[3]) begin
      if (!addr[2]) begin
        w_rdata = r_a[{addr[1:0], 3'b000} +: 8];
      end else begin
        w_rdata = r_b[{addr[1:0], 3'b000} +: 8];
      end
    end else if (addr[3:2] == 2'b11) begin
      w_rdata = r_result[{addr[1:0], 3'b000} +: 8];
    end else if (addr == LP_ADDR_STATUS) begin
      w_rdata = {6'b000000, w_done, w_busy};
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_data_out <= 8'h00;
    end else if (w_rd) begin
      r_data_out <= w_rdata;
    end
  end

  assign data_out  = r_data_out;
  assign busy      = w_busy;
  assign done      = w_done;
  assign a_operand = r_a;
  assign b_operand = r_b;
  assign operation = r_op;

endmodule

// File: tb/tb_fpu_bus_if.sv
// ---------------------------------------------------------------------------
// tb_fpu_bus_if
//
// Bench for fpu_bus_if. A stand-in fpu produces a known result for the
// reference vectors and a scrambled mix of its inputs otherwise; its output
// is garbage until the operands have been steady for two clocks, so an early
// capture shows up as a wrong RESULT. A transaction-level model tracks the
// register file, the remaining busy time and the done flag.
// ---------------------------------------------------------------------------
module tb_fpu_bus_if;

  localparam int SETTLE = 4;

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic            cs = 1'b0;
  logic            wr = 1'b0;
  logic            rd = 1'b0;
  logic [3:0]      addr = 4'd0;
  logic [7:0]      data_in = 8'h00;
  logic [7:0]      data_out;
  logic            busy;
  logic            done;
  logic [31:0]     a_operand;
  logic [31:0]     b_operand;
  pa_fpu::e_fpu_op operation;
  logic [31:0]     ieee_packet_out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  fpu_bus_if #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk            (clk),
    .arst           (arst),
    .cs             (cs),
    .wr             (wr),
    .rd             (rd),
    .addr           (addr),
    .data_in        (data_in),
    .data_out       (data_out),
    .busy           (busy),
    .done           (done),
    .a_operand      (a_operand),
    .b_operand      (b_operand),
    .operation      (operation),
    .ieee_packet_out(ieee_packet_out)
  );

  // Stand-in fpu
  function automatic logic [31:0] fpu_fn(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    if (a == 32'h3f800000 && b == 32'h3f8ccccd && op == 2'd0) return 32'h40066666;
    if (a == 32'h41800000 && b == 32'h42000000 && op == 2'd1) return 32'hc1800000;
    if (a == 32'h7f800000 && b == 32'h7f800000 && op == 2'd1) return 32'h7fc00000;
    return {a[15:0] ^ b[31:16], a[31:16] + b[15:0]} ^ {30'd0, op} ^ 32'h5a000000;
  endfunction

  logic [1:0]  op_bits;
  logic [65:0] prev_in = 66'd0;
  int          stab = 0;

  assign op_bits = operation;
  assign ieee_packet_out = (stab >= 2) ? fpu_fn(a_operand, b_operand, op_bits)
                                       : (32'hbad00000 ^ 32'(stab));

  always @(negedge clk) begin
    if ({a_operand, b_operand, op_bits} != prev_in) stab <= 0;
    else if (stab < 100) stab <= stab + 1;
    prev_in <= {a_operand, b_operand, op_bits};
  end

  // Reference model
  logic [31:0] m_a, m_b, m_res;
  logic [1:0]  m_op;
  logic [7:0]  m_dout, m_rdat;
  logic        m_done;
  int          m_left;
  logic        m_we, m_re;

  assign m_we = cs & wr;
  assign m_re = cs & rd & ~wr;

  always_comb begin
    m_rdat = 8'h00;
    if (addr < 4'd4)       m_rdat = m_a[8*addr[1:0] +: 8];
    else if (addr < 4'd8)  m_rdat = m_b[8*addr[1:0] +: 8];
    else if (addr == 4'd9) m_rdat = {6'd0, m_done, m_left > 0};
    else if (addr >= 4'd12) m_rdat = m_res[8*addr[1:0] +: 8];
  end

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_a <= 0; m_b <= 0; m_op <= 0; m_res <= 0; m_dout <= 0; m_done <= 0; m_left <= 0;
    end else begin
      if (m_re) m_dout <= m_rdat;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_res  <= fpu_fn(m_a, m_b, m_op);
          m_done <= 1'b1;
        end
      end else begin
        if (m_we && addr < 4'd4) m_a[8*addr[1:0] +: 8] <= data_in;
        if (m_we && addr >= 4'd4 && addr < 4'd8) m_b[8*addr[1:0] +: 8] <= data_in;
        if (m_we && addr == 4'd8 && data_in[7]) begin
          m_op   <= data_in[1:0];
          m_done <= 1'b0;
          m_left <= SETTLE + 1;
        end else if (m_re && addr == 4'd15) begin
          m_done <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("data_out", 32'(data_out), 32'(m_dout));
      chk("a_operand", a_operand, m_a);
      chk("b_operand", b_operand, m_b);
      chk("operation", 32'(op_bits), 32'(m_op));
    end
  end

  task automatic cyc(input bit c, input bit w, input bit r, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = c; wr = w; rd = r; addr = a; data_in = d;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 4'd0, 8'h00);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    cyc(1, 1, 0, a, d);
  endtask

  task automatic wr_word(input logic [3:0] base, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = v >> (8 * i);
      wr_reg(base + 4'(i), t[7:0]);
    end
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [7:0] exp);
    cyc(1, 0, 1, a, 8'h00);
    idle();
    chk(nm, 32'(data_out), 32'(exp));
  endtask

  task automatic rd_result(input string nm, input logic [31:0] exp);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = exp >> (8 * i);
      rd_chk(nm, 4'd12 + 4'(i), t[7:0]);
    end
  endtask

  task automatic wait_done(output int busy_cycles);
    bit seen;
    seen = 0;
    busy_cycles = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      idle();
      if (busy) busy_cycles++;
      if (done) seen = 1;
    end
    if (!seen) chk("wait_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int bc;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_a", a_operand, 32'd0);
    cmp_en = 1'b1;
    arst = 1'b0;

    rd_chk("result_before_capture", 4'd12, 8'h00);

    // 1.0 + 1.1
    wr_word(4'd0, 32'h3f800000);
    wr_word(4'd4, 32'h3f8ccccd);
    wr_reg(4'd8, 8'h80);
    wait_done(bc);
    chk("busy_len", 32'(bc), 32'(SETTLE + 1));
    chk("done_after", 32'(done), 32'd1);
    rd_result("add_res", 32'h40066666);
    chk("ack_done", 32'(done), 32'd0);

    // 16 - 32
    wr_word(4'd0, 32'h41800000);
    wr_word(4'd4, 32'h42000000);
    wr_reg(4'd8, 8'h81);
    wait_done(bc);
    rd_result("sub_res", 32'hc1800000);
    chk("sub_ack_done", 32'(done), 32'd0);
    chk("sub_ack_busy", 32'(busy), 32'd0);

    // inf - inf
    wr_word(4'd0, 32'h7f800000);
    wr_word(4'd4, 32'h7f800000);
    wr_reg(4'd8, 8'h81);
    wait_done(bc);
    rd_chk("status_done", 4'd9, 8'h02);
    rd_result("nan_res", 32'h7fc00000);

    // Writes while busy are dropped
    wr_word(4'd0, 32'h3f800000);
    wr_word(4'd4, 32'h3f8ccccd);
    wr_reg(4'd8, 8'h80);
    wr_reg(4'd0, 8'hff);
    wr_reg(4'd8, 8'h82);
    idle();
    chk("busy_a_hold", a_operand, 32'h3f800000);
    chk("busy_op_hold", 32'(op_bits), 32'd0);
    rd_chk("status_busy", 4'd9, 8'h01);
    wait_done(bc);
    rd_result("busy_res", 32'h40066666);

    // Simultaneous write and read
    rd_chk("rd_a3", 4'd3, 8'h3f);
    cyc(1, 1, 1, 4'd9, 8'h55);
    idle();
    chk("wr_rd_hold", 32'(data_out), 32'h3f);
    rd_chk("reserved", 4'd10, 8'h00);

    // Reset mid-SETTLE
    wr_reg(4'd8, 8'h80);
    idle();
    idle();
    @(posedge clk);
    #2 arst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_a", a_operand, 32'd0);
    chk("arst_dout", 32'(data_out), 32'd0);
    @(negedge clk);
    arst = 1'b0;
    wr_word(4'd0, 32'h41800000);
    rd_chk("arst_result", 4'd15, 8'h00);
    wr_word(4'd4, 32'h42000000);
    wr_reg(4'd8, 8'h81);
    wait_done(bc);
    rd_result("post_rst_res", 32'hc1800000);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        @(negedge clk);
        arst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0;
        @(negedge clk);
        arst = 1'b0;
      end else begin
        logic [3:0] a;
        logic [7:0] d;
        int s;
        s = int'($urandom_range(0, 99));
        d = 8'($urandom);
        if (s < 25) begin
          a = 4'd8;
          if ($urandom_range(0, 3) != 0) d[7] = 1'b1;
        end else if (s < 40) begin
          a = 4'd15;
        end else begin
          a = 4'($urandom);
        end
        cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
            $urandom_range(0, 9) < 5, a, d);
      end
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_bus_if.md
FPU_BUS_IF -- requirements
Module: fpu_bus_if

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, giving the number of clocks allowed for the combinational fpu to settle (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port arst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port cs, input, 1 bit: chip select from the 8-bit CPU bus.
REQ-005 The block SHALL have port wr, input, 1 bit: write strobe, qualified by cs.
REQ-006 The block SHALL have port rd, input, 1 bit: read strobe, qualified by cs.
REQ-007 The block SHALL have port addr, input, 4 bits: register select.
REQ-008 The block SHALL have port data_in, input, 8 bits: write data.
REQ-009 The block SHALL have port data_out, output, 8 bits: registered read data.
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: a result is held and not yet consumed.
REQ-012 The block SHALL have port a_operand, output, 32 bits: operand A to the fpu.
REQ-013 The block SHALL have port b_operand, output, 32 bits: operand B to the fpu.
REQ-014 The block SHALL have port operation, output, pa_fpu::e_fpu_op: operation to the fpu.
REQ-015 The block SHALL have port ieee_packet_out, input, 32 bits: combinational fpu result.

Function
REQ-016 Register map: 0-3 A bytes (little-endian: addr 0 = A[7:0]); 4-7 B bytes; 8 CMD (write only); 9 STATUS (read only); 12-15 RESULT bytes (little-endian, read only); 10, 11 reserved (read 0x00, writes ignored).
REQ-017 A write occurs on any cycle with cs=1 and wr=1; a read occurs on any cycle with cs=1 and rd=1; if wr and rd are both 1 in the same cycle, the write SHALL occur and the read SHALL be ignored.
REQ-018 A write to addresses 0-7 SHALL update the addressed byte on that edge only when state is IDLE or DONE; while busy=1 it SHALL be ignored.
REQ-019 A CMD write with data_in[7]=1 in IDLE or DONE SHALL start an operation: operation <= data_in[1:0] (0 op_add, 1 op_sub, 2 op_mul, 3 op_div), done <= 0, state <= SETTLE.
REQ-020 A CMD write with data_in[7]=0, or any CMD write while busy=1, SHALL be ignored.
REQ-021 FSM states: IDLE, SETTLE, CAPTURE, DONE.
REQ-022 IDLE: on a start write go to SETTLE.
REQ-023 SETTLE: a 4-bit counter loads 0 on entry and increments each cycle; after SETTLE_CYCLES cycles in SETTLE go to CAPTURE.
REQ-024 CAPTURE: the RESULT register <= ieee_packet_out, then go to DONE; this state lasts exactly 1 cycle.
REQ-025 DONE: accept operand writes and a new start; a read of addr 15 SHALL clear done and return to IDLE on the same edge.
REQ-026 busy SHALL be 1 exactly in SETTLE and CAPTURE, i.e. for SETTLE_CYCLES+1 cycles starting the cycle after the start write.
REQ-027 done SHALL be 1 exactly in DONE.
REQ-028 a_operand, b_operand and operation SHALL hold stable from start through CAPTURE.
REQ-029 A read SHALL update data_out on the next edge with the addressed byte.
REQ-030 STATUS read SHALL return {6'b0, done, busy}.
REQ-031 CMD and reserved reads SHALL return 0x00.
REQ-032 data_out SHALL hold its value between reads.
REQ-033 Reads of RESULT before any capture SHALL return 0x00.

Reset
REQ-034 While arst=1: state=IDLE, counter=0, a_operand=0, b_operand=0, operation=op_add, RESULT=0, data_out=0x00, busy=0, done=0.
REQ-035 Reset asserted mid-operation SHALL abort it with no capture; after release the block SHALL accept new writes on the first clock edge.

Verification
REQ-036 Write A=3f800000, B=3f8ccccd, CMD=0x80 -> busy for 5 cycles (default SETTLE_CYCLES); done=1; RESULT bytes 66,66,06,40.
REQ-037 A=41800000, B=42000000, CMD=0x81 -> RESULT=c1800000; reading addr 15 clears done and returns to IDLE.
REQ-038 A=7f800000, B=7f800000, CMD=0x81 -> RESULT=7fc00000; STATUS reads 0x02 after completion.
REQ-039 During busy: write addr 0=0xFF and CMD=0x82 -> both ignored; a_operand and operation unchanged; RESULT equals the original operation's result.
REQ-040 Assert arst during SETTLE -> all outputs at reset values immediately; RESULT=0; a following start completes normally.
REQ-041 Simultaneous wr and rd at addr 9 -> no read; data_out keeps its previous value.
